// File: rtl/mont_pkg.sv
// Shared types for the word-serial CIOS Montgomery multiplier.
package mont_pkg;

    localparam int MONT_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MULT,
        ST_MCOMP,
        ST_RED,
        ST_FINAL,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic [MONT_W-1:0] hi;
        logic [MONT_W-1:0] lo;
    } mac_t;

endpackage

// File: rtl/mont_mul_cios_mac.sv
// Single-word multiply-accumulate {hi,lo} = x + y*z + cin; purely combinational.
// Worst case (2^32-1) + (2^32-1)^2 + (2^32-1) = 2^64-1, so the 64-bit result never overflows.
module mont_mac
    import mont_pkg::*;
(
    input  logic [MONT_W-1:0] x_i,
    input  logic [MONT_W-1:0] y_i,
    input  logic [MONT_W-1:0] z_i,
    input  logic [MONT_W-1:0] cin_i,
    output mac_t              res_o
);

    assign res_o = {{MONT_W{1'b0}}, x_i}
                 + ({{MONT_W{1'b0}}, y_i} * {{MONT_W{1'b0}}, z_i})
                 + {{MONT_W{1'b0}}, cin_i};

endmodule

// File: rtl/mont_mul_cios.sv
// CIOS Montgomery multiply a*b*2^-WIDTH mod n; MONT_FINAL_SUB_EN adds the final conditional subtract.
// Latency: done rises S*(2S+1)+2 edges after the start edge (one fewer without MONT_FINAL_SUB_EN).
// Backpressure: start is accepted only when idle and not in the done cycle; otherwise dropped.
module mont_mul_cios
    import mont_pkg::*;
#(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] n_i,
    input  logic [31:0]      n0prime_i,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int S  = WIDTH / MONT_W;
    localparam int TW = WIDTH + 2 * MONT_W;
    localparam int IW = $clog2(S) + 1;
    localparam logic [IW-1:0] LAST = IW'(S - 1);

    state_e            state_q;
    logic [WIDTH-1:0]  a_q, b_q, n_q, result_q;
    logic [MONT_W-1:0] n0p_q, m_q, c_q;
    logic [TW-1:0]     t_q, t_d;
    logic [IW-1:0]     i_q, j_q;
    logic              busy_q, done_q;

    logic [MONT_W-1:0] mac_x, mac_y, mac_z, mac_cin;
    mac_t              mac_r;
    logic [MONT_W:0]   top_sum;
    logic              last_j;

    assign last_j  = (j_q == LAST);
    assign top_sum = {1'b0, t_q[S*MONT_W +: MONT_W]} + {1'b0, mac_r.hi};

    // One MAC serves all phases; MCOMP only keeps the low word of t[0]*n0prime.
    always_comb begin
        mac_x   = '0;
        mac_y   = '0;
        mac_z   = '0;
        mac_cin = '0;
        case (state_q)
            ST_MULT: begin
                mac_x   = t_q[int'(j_q)*MONT_W +: MONT_W];
                mac_y   = a_q[int'(i_q)*MONT_W +: MONT_W];
                mac_z   = b_q[int'(j_q)*MONT_W +: MONT_W];
                mac_cin = c_q;
            end
            ST_RED: begin
                mac_x   = t_q[int'(j_q)*MONT_W +: MONT_W];
                mac_y   = m_q;
                mac_z   = n_q[int'(j_q)*MONT_W +: MONT_W];
                mac_cin = c_q;
            end
            ST_MCOMP: begin
                mac_y = t_q[MONT_W-1:0];
                mac_z = n0p_q;
            end
            default: ;
        endcase
    end

    mont_mac u_mac (
        .x_i   (mac_x),
        .y_i   (mac_y),
        .z_i   (mac_z),
        .cin_i (mac_cin),
        .res_o (mac_r)
    );

    // RED writes word j into slot j-1, so the accumulator shifts down one word per outer pass.
    always_comb begin
        t_d = t_q;
        case (state_q)
            ST_IDLE: t_d = '0;
            ST_MULT: begin
                t_d[int'(j_q)*MONT_W +: MONT_W] = mac_r.lo;
                if (last_j) begin
                    t_d[S*MONT_W +: MONT_W]     = top_sum[MONT_W-1:0];
                    t_d[(S+1)*MONT_W +: MONT_W] = {{(MONT_W-1){1'b0}}, top_sum[MONT_W]};
                end
            end
            ST_RED: begin
                if (j_q != '0)
                    t_d[(int'(j_q)-1)*MONT_W +: MONT_W] = mac_r.lo;
                if (last_j) begin
                    t_d[(S-1)*MONT_W +: MONT_W] = top_sum[MONT_W-1:0];
                    t_d[S*MONT_W +: MONT_W]     = t_q[(S+1)*MONT_W +: MONT_W]
                                                + {{(MONT_W-1){1'b0}}, top_sum[MONT_W]};
                    t_d[(S+1)*MONT_W +: MONT_W] = '0;
                end
            end
            default: ;
        endcase
    end

`ifdef MONT_FINAL_SUB_EN
    logic             ge_n;
    logic [WIDTH-1:0] diff;
    assign ge_n = (t_q[WIDTH+MONT_W-1:0] >= {{MONT_W{1'b0}}, n_q});
    assign diff = t_q[WIDTH-1:0] - n_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            n0p_q    <= '0;
            t_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            m_q      <= '0;
            c_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            t_q <= t_d;
            case (state_q)
                ST_IDLE: begin
                    // done_q high here marks the done cycle; a start then is dropped.
                    done_q <= 1'b0;
                    i_q    <= '0;
                    j_q    <= '0;
                    c_q    <= '0;
                    busy_q <= start_i && !done_q;
                    if (start_i && !done_q) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        n_q     <= n_i;
                        n0p_q   <= n0prime_i;
                        state_q <= ST_MULT;
                    end
                end
                ST_MULT: begin
                    c_q <= mac_r.hi;
                    j_q <= j_q + 1'b1;
                    if (last_j) begin
                        c_q     <= '0;
                        j_q     <= '0;
                        state_q <= ST_MCOMP;
                    end
                end
                ST_MCOMP: begin
                    m_q     <= mac_r.lo;
                    state_q <= ST_RED;
                end
                ST_RED: begin
                    c_q <= mac_r.hi;
                    j_q <= j_q + 1'b1;
                    if (last_j) begin
                        c_q     <= '0;
                        j_q     <= '0;
                        i_q     <= i_q + 1'b1;
                        state_q <= ST_MULT;
                        if (i_q == LAST) begin
                            i_q <= '0;
`ifdef MONT_FINAL_SUB_EN
                            state_q <= ST_FINAL;
`else
                            result_q <= t_d[WIDTH-1:0];
                            state_q  <= ST_DONE;
`endif
                        end
                    end
                end
`ifdef MONT_FINAL_SUB_EN
                ST_FINAL: begin
                    result_q <= ge_n ? diff : t_q[WIDTH-1:0];
                    state_q  <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign result_o = result_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_mont_mul_cios.sv
// Randomized bench for mont_mul_cios at WIDTH=64 against a full-width REDC reference.
module tb_mont_mul_cios;

    localparam logic [63:0] N   = 64'hFFFF_FFFF_FFFF_FFC5;
    localparam logic [31:0] N0P = 32'hA08A_D8F3;
`ifdef MONT_FINAL_SUB_EN
    localparam int LAT = 12;
`else
    localparam int LAT = 11;
`endif

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [63:0] a_i, b_i, n_i;
    logic [31:0] n0p_i;
    logic [63:0] result_o;
    logic        busy_o, done_o;

    int tests = 0;
    int fails = 0;

    mont_mul_cios #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .n_i       (n_i),
        .n0prime_i (n0p_i),
        .result_o  (result_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got running, want finished)");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Whole-operand REDC: (a*b + m*n) / 2^64 with m = a*b*(-n^-1) mod 2^64.
    function automatic logic [63:0] mont_ref(input logic [63:0] a, input logic [63:0] b);
        logic [63:0]  inv, np, m;
        logic [127:0] t;
        logic [128:0] u;
        logic [64:0]  r;
        inv = N;
        for (int k = 0; k < 5; k++) inv = inv * (64'd2 - N * inv);
        np = -inv;
        t  = {64'd0, a} * {64'd0, b};
        m  = t[63:0] * np;
        u  = {1'b0, t} + {65'd0, m} * {65'd0, N};
        r  = u[128:64];
`ifdef MONT_FINAL_SUB_EN
        if (r >= {1'b0, N}) r = r - {1'b0, N};
`endif
        return r[63:0];
    endfunction

    function automatic logic [63:0] rand_op();
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        if (v >= N) v = v - N;
        return v;
    endfunction

    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done_o && lat < 100);
        check_eq("done_seen", {63'd0, done_o}, 64'd1);
    endtask

    task automatic drive_start(input logic [63:0] a, input logic [63:0] b);
        @(posedge clk); #1;
        a_i = a; b_i = b; n_i = N; n0p_i = N0P; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        a_i = {$urandom(), $urandom()};
        b_i = {$urandom(), $urandom()};
        n_i = {$urandom(), $urandom()};
        n0p_i = $urandom();
    endtask

    task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] res, output int lat);
        drive_start(a, b);
        check_eq("busy_after_start", {63'd0, busy_o}, 64'd1);
        wait_done(lat);
        res = result_o;
    endtask

    initial begin
        logic [63:0] r, aa, bb, a2, b2;
        int lat, dcnt;

        rst_n = 1'b0; start_i = 1'b0;
        a_i = '0; b_i = '0; n_i = '0; n0p_i = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_result", result_o, 64'd0);
        check_eq("rst_busy", {63'd0, busy_o}, 64'd0);
        check_eq("rst_done", {63'd0, done_o}, 64'd0);
        rst_n = 1'b1;

        do_op(64'd59, 64'd12345, r, lat);
`ifdef MONT_FINAL_SUB_EN
        check_eq("a59_b12345", r, 64'd12345);
`else
        check_eq("a59_b12345", r, mont_ref(64'd59, 64'd12345));
`endif
        check_eq("latency", lat, LAT);
        @(posedge clk); #1;
        check_eq("done_one_cycle", {63'd0, done_o}, 64'd0);
        check_eq("busy_cleared", {63'd0, busy_o}, 64'd0);

        do_op(64'd0, 64'd12345, r, lat);
        check_eq("a0_b12345", r, 64'd0);

        do_op(64'd59, 64'd59, r, lat);
`ifdef MONT_FINAL_SUB_EN
        check_eq("a59_b59", r, 64'd59);
`else
        check_eq("a59_b59", r, mont_ref(64'd59, 64'd59));
`endif

        do_op(64'd59, N - 64'd1, r, lat);
`ifdef MONT_FINAL_SUB_EN
        check_eq("a59_bnm1", r, 64'hFFFF_FFFF_FFFF_FFC4);
`else
        check_eq("a59_bnm1", r, mont_ref(64'd59, N - 64'd1));
`endif

        // Second start mid-operation must be dropped.
        aa = rand_op(); bb = rand_op(); a2 = rand_op(); b2 = rand_op();
        drive_start(aa, bb);
        repeat (3) @(posedge clk);
        #1;
        a_i = a2; b_i = b2; n_i = N; n0p_i = N0P; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        dcnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done_o) begin
                dcnt++;
                r = result_o;
            end
        end
        check_eq("midop_done_count", dcnt, 1);
        check_eq("midop_result", r, mont_ref(aa, bb));

        // Start during the done cycle is dropped; the following cycle accepts it.
        do_op(rand_op(), rand_op(), r, lat);
        aa = rand_op(); bb = rand_op();
        a_i = aa; b_i = bb; n_i = N; n0p_i = N0P; start_i = 1'b1;
        @(posedge clk); #1;
        check_eq("start_in_done_ignored", {63'd0, busy_o}, 64'd0);
        @(posedge clk); #1;
        start_i = 1'b0;
        check_eq("start_after_done_taken", {63'd0, busy_o}, 64'd1);
        wait_done(lat);
        check_eq("after_done_latency", lat, LAT);
        check_eq("after_done_result", result_o, mont_ref(aa, bb));

        // Reset in the middle of an operation.
        drive_start(rand_op(), rand_op());
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("abort_result", result_o, 64'd0);
        check_eq("abort_busy", {63'd0, busy_o}, 64'd0);
        check_eq("abort_done", {63'd0, done_o}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done_o) dcnt++;
        end
        check_eq("abort_no_done", dcnt, 0);
        aa = rand_op(); bb = rand_op();
        do_op(aa, bb, r, lat);
        check_eq("post_abort_result", r, mont_ref(aa, bb));

        for (int k = 0; k < 20; k++) begin
            aa = rand_op(); bb = rand_op();
            do_op(aa, bb, r, lat);
            check_eq($sformatf("rand%0d", k), r, mont_ref(aa, bb));
            check_eq($sformatf("rand%0d_lat", k), lat, LAT);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mont_mul_cios.md
# mont_mul_cios

Word-serial Montgomery multiplier using the CIOS (coarsely integrated operand scanning) method. It computes result = a·b·R⁻¹ mod n with R = 2^WIDTH. It sits directly downstream of n0prime and consumes its qinv output as n0prime = −n⁻¹ mod 2^32. It is the core multiply used by the RSA decryption exponentiation loop.

## Interface
- WIDTH, 512: operand width in bits; must be a multiple of 32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- a  input  WIDTH  multiplicand, a < n; sampled on the accepted start.
- b  input  WIDTH  multiplier, b < n; sampled on the accepted start.
- n  input  WIDTH  odd modulus; sampled on the accepted start.
- n0prime  input  32  −n⁻¹ mod 2^32, from n0prime.qinv; sampled on the accepted start.
- result  output  WIDTH  Montgomery product; valid from done until the next accepted start.
- busy  output  1  high from the cycle after an accepted start through the done cycle.
- done  output  1  one-cycle pulse when result is valid.

## Operation
- S = WIDTH/32 words. Accumulator t has S+2 words. Operands are latched into internal registers on start.
- States: IDLE → MULT → MCOMP → RED → (MULT | FINAL) → DONE → IDLE.
- IDLE: t cleared, i = 0. start=1 latches operands and moves to MULT with j = 0.
- MULT (S cycles, j = 0..S−1): (C,Sw) = t[j] + a[i]·b[j] + C; t[j] ← Sw. On j = S−1 also: t[S] ← t[S] + C (low word), t[S+1] ← carry of that add.
- MCOMP (1 cycle): m ← (t[0]·n0prime) mod 2^32.
- RED (S cycles, j = 0..S−1): (C,Sw) = t[j] + m·n[j] + C; for j ≥ 1, t[j−1] ← Sw (word shift right). On j = S−1 also: t[S−1] ← t[S] + C (low word), t[S] ← t[S+1] + carry, t[S+1] ← 0. Then i ← i+1; i = S goes to FINAL, otherwise MULT with j = 0.
- The word-0 RED sum is discarded; it is 0 by construction.
- FINAL (1 cycle): if {t[S],t[S−1..0]} ≥ n, result ← t − n, else result ← t[S−1..0].
- DONE (1 cycle): done = 1, then IDLE.
- All MAC arithmetic is 32×32 + 32 + 32, which fits in 64 bits without overflow.

## Timing
- Reset: state IDLE; result = 0, done = 0, busy = 0; t, i, j, m, C all 0.
- Latency: start sampled at edge k; done is high in the cycle after edge k + S·(2S+1) + 2. For WIDTH=512 that is 530 cycles; for WIDTH=64 it is 12.
- start while busy is ignored. Operands are not re-sampled.
- start in the DONE cycle is ignored. start in the cycle after done is accepted.
- rst_n low mid-operation aborts immediately to reset values. No done is produced for the aborted operation.
- Inputs may change freely after the start cycle.

## Configuration
- MONT_FINAL_SUB_EN defined: FINAL state present; result is in [0, n).
- MONT_FINAL_SUB_EN undefined: FINAL is skipped and result ← t[S−1..0] on RED exit; result is in [0, 2n) (almost-Montgomery); latency is one cycle less.

## Structure
- Package mont_pkg: word width constant MONT_W = 32, the state enum, and a 64-bit MAC result typedef.
- One sub-module, mont_mac: combinational {C,S} = x + y·z + cin for 32-bit operands. It is instantiated once and shared by MULT, RED and MCOMP (MCOMP uses x = 0, cin = 0, low word only).
- Word selection uses indexed part-selects on the latched operands; there are no memories.

## Test plan
All scenarios use WIDTH=64, n = 0xFFFFFFFFFFFFFFC5, n0prime = 0xA08AD8F3, and R mod n = 59.
- a = 59, b = 12345: result = 12345; done exactly 12 cycles after start (11 with the macro undefined).
- a = 0, b = 12345: result = 0.
- a = 59, b = 59: result = 59.
- a = 59, b = n−1 with the macro defined: result = 0xFFFFFFFFFFFFFFC4.
- Second start pulsed mid-operation with different operands: ignored; the first result is unchanged; exactly one done.
- rst_n low at cycle 6 of an operation: result, busy and done read 0; no done. A fresh start after release gives the correct result.
